spmv_fp_row_accum: RTL
======================

Name: spmv_fp_row_accum

Overview:
Parametrised floating-point row accumulator for the SpMV datapath. It is the successor to the fixed fp16 two-operand adder.
- Sums a stream of multiplier products, one per accepted beat, into a running per-row sum.
- Emits the row sum and the row's nonzero count when the beat tagged last is accepted.
- Sits between the fp multiplier and the y-vector writeback.
- Uses valid/ready on both sides.

Parameters:
EXP_W, 5, exponent width (bias = 2^(EXP_W-1)-1)
MAN_W, 10, stored mantissa width; FP_W = 1+EXP_W+MAN_W
CNT_W, 16, width of per-row beat counter

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  reset, synchronous, active-low
i_valid  in  1  product beat valid
i_ready  out  1  block can accept beat
i_data  in  FP_W  product (sign|exp|man)
i_last  in  1  beat is last of current row
o_valid  out  1  row result valid
o_ready  in  1  downstream accepts result
o_sum  out  FP_W  row sum
o_cnt  out  CNT_W  beats accumulated in row (saturating)

Behaviour:
Reset (i_rstn=0 at posedge):
- acc=+0, cnt=0, o_valid=0, o_sum=0, o_cnt=0.
- Any row in progress is discarded.

Handshake:
- i_ready = !o_valid || o_ready (combinational).
- A beat is accepted when i_valid && i_ready.
- A result transfers when o_valid && o_ready.
- o_sum/o_cnt are stable while o_valid && !o_ready.

Accepted beat, not last:
- acc <= fpadd(acc, i_data).
- cnt <= sat(cnt+1).

Accepted beat, last:
- o_sum <= fpadd(acc, i_data); o_cnt <= sat(cnt+1); o_valid <= 1.
- acc <= +0; cnt <= 0.
- Latency: last beat accepted at edge N, result visible after edge N.

Simultaneous events:
- Result transfer with no new last beat: o_valid <= 0.
- Result transfer and new last beat on the same edge: o_valid stays 1 with the new data.

Single-beat row: o_sum = fpadd(+0, i_data).

fpadd rules (combinational, one cycle):
- Compare magnitudes, align the smaller operand by exponent difference; guard bits are discarded on shift-out.
- Add or subtract the hidden-bit mantissas, then normalise (left shift by leading-zero count, or right shift by 1 on carry).
- Rounding: truncation, i.e. round toward zero.
- Subnormal inputs are flushed to zero.
- Underflowing results go to +0.
- Exact cancellation gives +0.
- Exponent overflow gives ±Inf (exp all ones, man 0).
- Inf + finite = Inf.
- +Inf + -Inf = NaN.
- Any NaN input gives canonical NaN (exp all ones, man MSB=1, sign 0).

Counter: saturates at 2^CNT_W-1 and never wraps.

Reset mid-row or with o_valid held: all state clears, nothing is emitted.

Test Plan:
- Reset: hold i_rstn=0 for 3 cycles with i_valid=1 -> o_valid=0, o_sum=0x0000, o_cnt=0; release -> i_ready=1.
- Two-beat row (fp16): 0x4C00 (16.0), then 0x4000 (2.0) with last -> o_sum=0x4C80 (18.0), o_cnt=2 one edge after last.
- Three-beat row with backpressure: 16.0, 2.0, 0x5400 (64.0) last, o_ready=0 for 4 cycles -> o_sum=0x5520 (82.0), o_cnt=3 held stable; i_ready=0 until o_ready=1; next row starts from +0.
- Special cases, one single/two-beat row each:
  - 0x4000 + 0xC000 -> 0x0000.
  - 0x7BFF + 0x7BFF -> 0x7C00.
  - 0x7C00 + 0xFC00 -> 0x7E00.
  - 0x3C00 + 0x1000 -> 0x3C00 (truncation).
- Back-to-back rows: last on consecutive cycles with o_ready=1 -> one result per cycle, o_valid continuously 1, correct o_cnt=1 each.
- Reset mid-row: 2 beats accepted, reset, then row {0x3C00 last} -> o_sum=0x3C00, o_cnt=1.

Source files
------------

// File: rtl/spmv_fp_row_accum.sv
// Floating-point row accumulator for the SpMV datapath: sums product beats per row
// with a truncating single-cycle fp adder and emits the sum plus a saturating beat count.
module spmv_fp_row_accum #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [EXP_W+MAN_W:0]   i_data,
  input  logic                   i_last,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [EXP_W+MAN_W:0]   o_sum,
  output logic [CNT_W-1:0]       o_cnt
);

  localparam int FP_W = 1 + EXP_W + MAN_W;
  localparam int S_W  = MAN_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [MAN_W-1:0] MAN_ZERO = {MAN_W{1'b0}};
  localparam logic [FP_W-1:0]  FP_ZERO  = {FP_W{1'b0}};
  localparam logic [FP_W-1:0]  FP_QNAN  = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [FP_W-1:0] fpadd(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic [EXP_W-1:0] ea, eb, ebig, esml, ediff;
    logic [MAN_W-1:0] fa, fb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big, sbig, ssml;
    logic [S_W-1:0]   mbig, msml, r;
    logic [FP_W-1:0]  res;
    int               ex, msb;
    ea     = a[FP_W-2:MAN_W];
    eb     = b[FP_W-2:MAN_W];
    fa     = a[MAN_W-1:0];
    fb     = b[MAN_W-1:0];
    a_nan  = (ea == EXP_ONES) && (fa != MAN_ZERO);
    b_nan  = (eb == EXP_ONES) && (fb != MAN_ZERO);
    a_inf  = (ea == EXP_ONES) && (fa == MAN_ZERO);
    b_inf  = (eb == EXP_ONES) && (fb == MAN_ZERO);
    a_zero = (ea == EXP_ZERO);
    b_zero = (eb == EXP_ZERO);
    a_big  = (a[FP_W-2:0] >= b[FP_W-2:0]);
    sbig   = a_big ? a[FP_W-1] : b[FP_W-1];
    ssml   = a_big ? b[FP_W-1] : a[FP_W-1];
    ebig   = a_big ? ea : eb;
    esml   = a_big ? eb : ea;
    mbig   = {1'b0, 1'b1, (a_big ? fa : fb)};
    msml   = {1'b0, 1'b1, (a_big ? fb : fa)};
    ediff  = ebig - esml;
    // Bits shifted out of the smaller operand are dropped before the add.
    msml   = msml >> ediff;
    r      = (sbig == ssml) ? (mbig + msml) : (mbig - msml);
    ex     = int'(ebig);
    msb    = 0;
    if (r[S_W-1]) begin
      r  = r >> 1;
      ex = ex + 1;
    end else begin
      for (int i = 0; i < S_W - 1; i++) begin
        if (r[i]) msb = i;
        else      msb = msb;
      end
      r  = r << (MAN_W - msb);
      ex = ex - (MAN_W - msb);
    end
    if (a_nan || b_nan)                 res = FP_QNAN;
    else if (a_inf && b_inf)            res = (a[FP_W-1] != b[FP_W-1]) ? FP_QNAN : a;
    else if (a_inf)                     res = a;
    else if (b_inf)                     res = b;
    else if (a_zero && b_zero)          res = FP_ZERO;
    else if (a_zero)                    res = b;
    else if (b_zero)                    res = a;
    else if (r == {S_W{1'b0}})          res = FP_ZERO;
    else if (ex <= 0)                   res = FP_ZERO;
    else if (ex >= int'(EXP_ONES))      res = {sbig, EXP_ONES, MAN_ZERO};
    else                                res = {sbig, ex[EXP_W-1:0], r[MAN_W-1:0]};
    return res;
  endfunction

  logic [FP_W-1:0]  acc_q, acc_d, sum_q, sum_d, add_s;
  logic [CNT_W-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d, cnt_inc_s;
  logic             valid_q, valid_d, beat_s;

  assign i_ready   = !valid_q || o_ready;
  assign beat_s    = i_valid && i_ready;
  assign add_s     = fpadd(acc_q, i_data);
  assign cnt_inc_s = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ocnt_d  = ocnt_q;
    valid_d = valid_q;
    if (valid_q && o_ready) valid_d = 1'b0;
    else                    valid_d = valid_q;
    // A last beat on a transfer edge overrides the clear above, keeping o_valid high.
    if (beat_s) begin
      if (i_last) begin
        sum_d   = add_s;
        ocnt_d  = cnt_inc_s;
        valid_d = 1'b1;
        acc_d   = FP_ZERO;
        cnt_d   = {CNT_W{1'b0}};
      end else begin
        acc_d   = add_s;
        cnt_d   = cnt_inc_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      acc_q   <= FP_ZERO;
      cnt_q   <= {CNT_W{1'b0}};
      sum_q   <= FP_ZERO;
      ocnt_q  <= {CNT_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ocnt_q  <= ocnt_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_cnt   = ocnt_q;

endmodule
